countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Down-counting companion to the stopwatch: loads a preset time (seconds + milliseconds,
//  max 59 s 999 ms), counts down one ms per internal tick, and flags expiry at 0:000.
//  Sits beside the stopwatch and feeds the same 7-seg display path (same output fields).
//  Ms tick comes from an internal clock-enable prescaler; no derived clocks.
// PARAMETERS
//  TICK_DIV  50_000  clk cycles per 1 ms tick (50 MHz -> 1 kHz); must be >= 2
// PORTS
//  clk             in   1   system clock, all logic on posedge
//  rst_a_n         in   1   async reset, active-low
//  load            in   1   1-cycle strobe: capture preset_s/preset_ms, go IDLE
//  preset_s        in   6   preset seconds (0..59; larger values saturate to 59)
//  preset_ms       in   10  preset milliseconds (0..999; larger values saturate to 999)
//  start           in   1   1-cycle strobe: begin countdown from IDLE
//  pause           in   1   level: 1 = hold count while running
//  ms_counter      out  10  remaining ms field, 0..999
//  second_counter  out  6   remaining s field, 0..59
//  running         out  1   1 while state == RUN
//  expired         out  1   1 while state == DONE
//  done_pulse      out  1   exactly 1 cycle high on entry to DONE
// BEHAVIOUR
//  - Reset (rst_a_n=0, async): state IDLE, ms/s fields 0, prescaler 0, all outputs 0.
//  - Time held as two registered fields (s, ms) with borrow; no divider/modulo logic.
//  - Prescaler: counts 0..TICK_DIV-1 only in RUN; tick = 1 for one cycle at TICK_DIV-1,
//    then wraps to 0. Held (not cleared) in PAUSED; cleared in IDLE and DONE.
//  - States: IDLE, RUN, PAUSED, DONE.
//    IDLE  : start & value!=0 -> RUN; start & value==0 -> DONE.
//    RUN   : tick -> decrement; pause=1 -> PAUSED; reaching 0:000 -> DONE.
//    PAUSED: pause=0 -> RUN (prescaler resumes from held phase). start ignored.
//    DONE  : fields stay 0:000; start/pause ignored; leave only via load or reset.
//  - Decrement on tick: ms>0 -> ms-1; ms==0 -> ms=999, s=s-1. Never decrements below 0:000.
//  - Expiry: on the edge where fields become 0:000, state becomes DONE on that same edge;
//    done_pulse is high for the following single cycle; expired stays high while DONE.
//  - load has priority over everything (any state): fields <= saturated preset,
//    state <= IDLE, prescaler <= 0, done_pulse/expired cleared next cycle.
//  - Same-cycle tick and pause=1 in RUN: decrement applied, then PAUSED.
//  - Same-cycle tick reaching 0:000 and pause=1: DONE wins.
//  - start with load in same cycle: load wins, start dropped.
//  - Outputs registered; running/expired decoded from state register.
// TESTING
//  1. TICK_DIV=4, load 0s/5ms, start -> ms 5,4,3,2,1,0 every 4 cycles; done_pulse 1 cycle
//     on the cycle after ms hits 0; expired stays 1; running falls same edge.
//  2. Borrow: load 2s/0ms, start -> after first tick s=1, ms=999; after 1000 ticks s=0,
//     ms=999.
//  3. Pause: load 1s/0ms, run 10 ticks (0:990), pause=1 for 100 cycles -> fields frozen at
//     0:990, running=0; release -> next tick occurs after remaining prescaler phase only.
//  4. Zero preset: load 0s/0ms, start -> DONE next edge, done_pulse 1 cycle, no ticks.
//  5. Saturation: load 63s/1023ms -> second_counter=59, ms_counter=999 while IDLE.
//  6. Mid-run disturbances: rst_a_n low mid-RUN -> outputs 0 immediately, IDLE after
//     release; load 3s/7ms during RUN -> IDLE, fields 3:007, start resumes countdown.

Source files
------------

// File: rtl/countdown_timer.sv
// Millisecond countdown timer (max 59 s 999 ms) with an internal 1 ms clock-enable prescaler.
// Exposes the same s/ms fields as the stopwatch so both can share one display path.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst_a_n,
    input  logic       load,
    input  logic [5:0] preset_s,
    input  logic [9:0] preset_ms,
    input  logic       start,
    input  logic       pause,
    output logic [9:0] ms_counter,
    output logic [5:0] second_counter,
    output logic       running,
    output logic       expired,
    output logic       done_pulse
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [9:0]    ms_q;
    logic [5:0]    s_q;
    logic          done_pulse_q;

    logic [9:0]    ms_d;
    logic [5:0]    s_d;
    logic          tick_s;
    logic          reach_zero_s;
    logic          is_zero_s;

    function automatic logic [5:0] sat_sec(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [9:0] sat_msec(input logic [9:0] v);
        return (v > 10'd999) ? 10'd999 : v;
    endfunction

    assign tick_s       = (state_q == ST_RUN) && (presc_q == TICK_LAST);
    assign is_zero_s    = (s_q == 6'd0) && (ms_q == 10'd0);
    assign reach_zero_s = (s_q == 6'd0) && (ms_q == 10'd1);

    // Decremented time value with borrow from seconds; holds at 0:000.
    always_comb begin
        ms_d = ms_q;
        s_d  = s_q;
        if (ms_q != 10'd0) begin
            ms_d = ms_q - 10'd1;
        end else if (s_q != 6'd0) begin
            ms_d = 10'd999;
            s_d  = s_q - 6'd1;
        end else begin
            ms_d = 10'd0;
            s_d  = 6'd0;
        end
    end

    // Timer state machine, prescaler, time fields and expiry pulse.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            ms_q         <= 10'd0;
            s_q          <= 6'd0;
            done_pulse_q <= 1'b0;
        end else if (load) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            ms_q         <= sat_msec(preset_ms);
            s_q          <= sat_sec(preset_s);
            done_pulse_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_q      <= '0;
                    done_pulse_q <= 1'b0;
                    if (start) begin
                        if (is_zero_s) begin
                            state_q      <= ST_DONE;
                            done_pulse_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    done_pulse_q <= 1'b0;
                    if (tick_s) begin
                        presc_q <= '0;
                        ms_q    <= ms_d;
                        s_q     <= s_d;
                        // Expiry outranks a simultaneous pause request.
                        if (reach_zero_s) begin
                            state_q      <= ST_DONE;
                            done_pulse_q <= 1'b1;
                        end else if (pause) begin
                            state_q <= ST_PAUSED;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                        state_q <= pause ? ST_PAUSED : ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    done_pulse_q <= 1'b0;
                    state_q      <= pause ? ST_PAUSED : ST_RUN;
                end
                ST_DONE: begin
                    presc_q      <= '0;
                    ms_q         <= 10'd0;
                    s_q          <= 6'd0;
                    done_pulse_q <= 1'b0;
                    state_q      <= ST_DONE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    presc_q      <= '0;
                    ms_q         <= 10'd0;
                    s_q          <= 6'd0;
                    done_pulse_q <= 1'b0;
                end
            endcase
        end
    end

    assign ms_counter     = ms_q;
    assign second_counter = s_q;
    assign running        = (state_q == ST_RUN);
    assign expired        = (state_q == ST_DONE);
    assign done_pulse     = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic, checked every cycle
// against a reference that tracks the remaining time as a single millisecond total.
module tb_countdown_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_a_n;
    logic       load;
    logic [5:0] preset_s;
    logic [9:0] preset_ms;
    logic       start;
    logic       pause;
    logic [9:0] ms_counter;
    logic [5:0] second_counter;
    logic       running;
    logic       expired;
    logic       done_pulse;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk            (clk),
        .rst_a_n        (rst_a_n),
        .load           (load),
        .preset_s       (preset_s),
        .preset_ms      (preset_ms),
        .start          (start),
        .pause          (pause),
        .ms_counter     (ms_counter),
        .second_counter (second_counter),
        .running        (running),
        .expired        (expired),
        .done_pulse     (done_pulse)
    );

    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;

    int      n_checks = 0;
    int      n_fail   = 0;
    mstate_t m_st;
    int      m_rem;
    int      m_phase;
    int      m_dp;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_rem = 0; m_phase = 0; m_dp = 0;
    endtask

    // One clock edge of the reference, using the inputs present at that edge.
    task automatic model_step();
        int s_sat, ms_sat;
        if (load) begin
            s_sat  = (preset_s > 59) ? 59 : int'(preset_s);
            ms_sat = (preset_ms > 999) ? 999 : int'(preset_ms);
            m_rem = s_sat * 1000 + ms_sat; m_st = M_IDLE; m_phase = 0; m_dp = 0;
        end else begin
            m_dp = 0;
            case (m_st)
                M_IDLE: begin
                    m_phase = 0;
                    if (start) begin
                        if (m_rem != 0) m_st = M_RUN;
                        else begin m_st = M_DONE; m_dp = 1; end
                    end
                end
                M_RUN: begin
                    if (m_phase == TD - 1) begin
                        m_phase = 0;
                        m_rem--;
                        if (m_rem == 0) begin m_st = M_DONE; m_dp = 1; end
                        else if (pause) m_st = M_PAUSED;
                    end else begin
                        m_phase++;
                        if (pause) m_st = M_PAUSED;
                    end
                end
                M_PAUSED: if (!pause) m_st = M_RUN;
                default: begin m_phase = 0; m_rem = 0; end
            endcase
        end
    endtask

    task automatic check_outputs();
        check_val("ms_counter", ms_counter, m_rem % 1000);
        check_val("second_counter", second_counter, m_rem / 1000);
        check_val("running", running, (m_st == M_RUN) ? 1 : 0);
        check_val("expired", expired, (m_st == M_DONE) ? 1 : 0);
        check_val("done_pulse", done_pulse, m_dp);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_load(input int s, input int ms);
        load = 1'b1; preset_s = 6'(s); preset_ms = 10'(ms);
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst_a_n = 1'b0; load = 1'b0; preset_s = 6'd0; preset_ms = 10'd0;
        start = 1'b0; pause = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_a_n = 1'b1;
        run(2);

        // Short countdown to expiry, then DONE ignores start/pause.
        do_load(0, 5);
        do_start();
        run(26);
        check_val("expired_after_5ms", expired, 1);
        start = 1'b1; pause = 1'b1;
        run(3);
        start = 1'b0; pause = 1'b0;

        // Borrow across a seconds boundary.
        do_load(2, 0);
        do_start();
        run(4);
        check_val("borrow_s", second_counter, 1);
        check_val("borrow_ms", ms_counter, 999);
        run(4000);
        check_val("borrow2_s", second_counter, 0);
        check_val("borrow2_ms", ms_counter, 999);

        // Pause holds the fields and prescaler phase; start is ignored while paused.
        do_load(1, 0);
        do_start();
        run(41);
        pause = 1'b1;
        run(50);
        start = 1'b1;
        cyc();
        start = 1'b0;
        run(49);
        check_val("paused_ms", ms_counter, 990);
        pause = 1'b0;
        run(12);

        // Zero preset expires straight away.
        do_load(0, 0);
        do_start();
        run(3);

        // Oversized presets saturate.
        do_load(63, 1023);
        check_val("sat_s", second_counter, 59);
        check_val("sat_ms", ms_counter, 999);
        run(2);

        // Asynchronous reset in the middle of a countdown.
        do_start();
        run(9);
        rst_a_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_a_n = 1'b1;
        run(2);

        // Reload during RUN; load beats a simultaneous start.
        do_load(0, 20);
        do_start();
        run(10);
        start = 1'b1;
        do_load(3, 7);
        start = 1'b0;
        check_val("reload_s", second_counter, 3);
        check_val("reload_ms", ms_counter, 7);
        check_val("reload_idle", running, 0);
        run(3);
        do_start();
        run(20);

        // Random traffic with mostly short presets.
        for (int i = 0; i < 4000; i++) begin
            load      = ($urandom % 50 == 0);
            preset_s  = ($urandom % 10 == 0) ? 6'($urandom) : 6'd0;
            preset_ms = ($urandom % 8 == 0) ? 10'($urandom) : 10'($urandom % 25);
            start     = ($urandom % 6 == 0);
            if ($urandom % 7 == 0) pause = ~pause;
            cyc();
        end
        load = 1'b0; start = 1'b0; pause = 1'b0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
